// File: rtl/pwm_sequencer.sv
// Sequencer for the gate-driver PWM datapath: step prescaler, soft start/stop
// duty ramping with bounded slew, and a latched hard-fault shutdown.
module pwm_sequencer #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 16,
    parameter int RAMP_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  fault_i,
    input  logic                  fault_clr_i,
    input  logic [N-1:0]          target_duty_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [RAMP_W-1:0]     ramp_div_i,
    output logic                  pwm_ena_o,
    output logic                  pwm_step_o,
    output logic [N-1:0]          pwm_duty_o,
    output logic                  at_target_o,
    output logic                  faulted_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        RUN,
        RAMP_DOWN,
        FAULT
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [RAMP_W-1:0]     ramp_q, ramp_d;
    logic [N-1:0]          duty_d;
    logic [N-1:0]          toward;
    logic                  step_tick;
    logic                  ramp_tick;

    // Counters compare with >= so a period lowered mid-count wraps at once.
    always_comb begin
        step_tick = (presc_q >= prescale_i);
        presc_d   = step_tick ? '0 : presc_q + 1'b1;
        ramp_tick = step_tick && (ramp_q >= ramp_div_i);

        if (pwm_duty_o < target_duty_i)
            toward = pwm_duty_o + 1'b1;
        else if (pwm_duty_o > target_duty_i)
            toward = pwm_duty_o - 1'b1;
        else
            toward = pwm_duty_o;

        state_d = state_q;
        duty_d  = pwm_duty_o;

        if (fault_i) begin
            state_d = FAULT;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (start_i && !stop_i)
                        state_d = RAMP_UP;
                end
                RAMP_UP: begin
                    if (stop_i) begin
                        state_d = RAMP_DOWN;
                    end else if (pwm_duty_o == target_duty_i) begin
                        state_d = RUN;
                    end else if (ramp_tick) begin
                        duty_d = toward;
                        if (toward == target_duty_i)
                            state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop_i)
                        state_d = RAMP_DOWN;
                    else if (ramp_tick)
                        duty_d = toward;
                end
                RAMP_DOWN: begin
                    if (start_i && !stop_i) begin
                        state_d = RAMP_UP;
                    end else if (pwm_duty_o == '0) begin
                        state_d = IDLE;
                    end else if (ramp_tick) begin
                        duty_d = pwm_duty_o - 1'b1;
                        if (duty_d == '0)
                            state_d = IDLE;
                    end
                end
                FAULT: begin
                    duty_d = '0;
                    if (fault_clr_i)
                        state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end

        // Every state change restarts the ramp divider so ramps begin on a clean period.
        if (state_d != state_q)
            ramp_d = '0;
        else if (ramp_tick)
            ramp_d = '0;
        else if (step_tick)
            ramp_d = ramp_q + 1'b1;
        else
            ramp_d = ramp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            ramp_q      <= '0;
            pwm_ena_o   <= 1'b0;
            pwm_step_o  <= 1'b0;
            pwm_duty_o  <= '0;
            at_target_o <= 1'b0;
            faulted_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            ramp_q      <= ramp_d;
            pwm_step_o  <= step_tick;
            pwm_duty_o  <= duty_d;
            pwm_ena_o   <= (state_d == RAMP_UP) || (state_d == RUN) || (state_d == RAMP_DOWN);
            busy_o      <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
            faulted_o   <= (state_d == FAULT);
            at_target_o <= (state_d == RUN) && (duty_d == target_duty_i);
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed testbench for pwm_sequencer: reset, prescaler, soft start, tracking,
// soft stop/resume, fault latch and saturation, checked with immediate assertions.
module tb_pwm_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        fault;
    logic        fault_clr;
    logic [7:0]  target;
    logic [15:0] prescale;
    logic [15:0] ramp_div;
    logic        pwm_ena;
    logic        pwm_step;
    logic [7:0]  pwm_duty;
    logic        at_target;
    logic        faulted;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pwm_sequencer #(.N(8), .PRESCALE_W(16), .RAMP_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .fault_i      (fault),
        .fault_clr_i  (fault_clr),
        .target_duty_i(target),
        .prescale_i   (prescale),
        .ramp_div_i   (ramp_div),
        .pwm_ena_o    (pwm_ena),
        .pwm_step_o   (pwm_step),
        .pwm_duty_o   (pwm_duty),
        .at_target_o  (at_target),
        .faulted_o    (faulted),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next duty change; reports the cycle count it took.
    task automatic waitChange(input string tag, input int budget, output int cyc);
        logic [7:0] prev;
        prev = pwm_duty;
        cyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (pwm_duty === prev && cyc < budget);
        checkOutput({tag, "_changed"}, {31'd0, pwm_duty !== prev}, 32'd1);
    endtask

    task automatic waitDuty(input string tag, input logic [7:0] value, input int budget);
        int cyc;
        cyc = 0;
        while (pwm_duty !== value && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(tag, {24'd0, pwm_duty}, {24'd0, value});
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic f, input logic fc);
        start     = s;
        stop      = p;
        fault     = f;
        fault_clr = fc;
    endtask

    initial begin
        int cyc;
        int highs;

        rst_n    = 1'b0;
        applyStimulus(0, 0, 0, 0);
        target   = 8'd0;
        prescale = 16'd3;
        ramp_div = 16'd1;

        // Reset state
        #12;
        checkOutput("rst_ena", {31'd0, pwm_ena}, 32'd0);
        checkOutput("rst_step", {31'd0, pwm_step}, 32'd0);
        checkOutput("rst_duty", {24'd0, pwm_duty}, 32'd0);
        checkOutput("rst_faulted", {31'd0, faulted}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_at_target", {31'd0, at_target}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler: one step in every four cycles, then every cycle
        repeat (3) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pwm_step) highs++;
        end
        checkOutput("presc3_count", highs, 32'd4);
        prescale = 16'd0;
        repeat (4) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pwm_step) highs++;
        end
        checkOutput("presc0_count", highs, 32'd8);

        // Soft start to 5, one LSB per 8 clocks
        prescale = 16'd3;
        ramp_div = 16'd1;
        target   = 8'd5;
        repeat (2) @(negedge clk);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        checkOutput("ss_ena", {31'd0, pwm_ena}, 32'd1);
        checkOutput("ss_busy", {31'd0, busy}, 32'd1);
        checkOutput("ss_duty0", {24'd0, pwm_duty}, 32'd0);
        start = 1'b0;
        waitChange("ss_first", 20, cyc);
        checkOutput("ss_first_le8", {31'd0, cyc <= 8}, 32'd1);
        checkOutput("ss_duty1", {24'd0, pwm_duty}, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            waitChange("ss_step", 20, cyc);
            checkOutput("ss_interval", cyc, 32'd8);
            checkOutput("ss_duty", {24'd0, pwm_duty}, k);
            checkOutput("ss_busy_k", {31'd0, busy}, (k < 5) ? 32'd1 : 32'd0);
        end
        checkOutput("ss_at_target", {31'd0, at_target}, 32'd1);

        // Tracking: slew down to 2 in RUN
        target = 8'd2;
        @(negedge clk);
        checkOutput("trk_at_target0", {31'd0, at_target}, 32'd0);
        waitChange("trk_first", 20, cyc);
        checkOutput("trk_duty4", {24'd0, pwm_duty}, 32'd4);
        waitChange("trk_b", 20, cyc);
        checkOutput("trk_interval", cyc, 32'd8);
        checkOutput("trk_duty3", {24'd0, pwm_duty}, 32'd3);
        waitChange("trk_c", 20, cyc);
        checkOutput("trk_duty2", {24'd0, pwm_duty}, 32'd2);
        checkOutput("trk_at_target1", {31'd0, at_target}, 32'd1);

        // Back to 5, then soft stop with a resume at 3
        target = 8'd5;
        waitDuty("trk_back5", 8'd5, 60);
        checkOutput("trk_back_at", {31'd0, at_target}, 32'd1);
        stop = 1'b1;
        @(negedge clk);
        checkOutput("stop_busy", {31'd0, busy}, 32'd1);
        checkOutput("stop_ena", {31'd0, pwm_ena}, 32'd1);
        checkOutput("stop_at_target", {31'd0, at_target}, 32'd0);
        waitChange("stop_a", 20, cyc);
        checkOutput("stop_duty4", {24'd0, pwm_duty}, 32'd4);
        waitChange("stop_b", 20, cyc);
        checkOutput("stop_interval", cyc, 32'd8);
        checkOutput("stop_duty3", {24'd0, pwm_duty}, 32'd3);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("resume_busy", {31'd0, busy}, 32'd1);
        checkOutput("resume_duty3", {24'd0, pwm_duty}, 32'd3);
        waitChange("resume_up", 20, cyc);
        checkOutput("resume_duty4", {24'd0, pwm_duty}, 32'd4);
        stop = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            waitChange("down", 20, cyc);
            checkOutput("down_duty", {24'd0, pwm_duty}, k);
            checkOutput("down_ena", {31'd0, pwm_ena}, 32'd1);
        end
        waitChange("down_zero", 20, cyc);
        checkOutput("down_duty0", {24'd0, pwm_duty}, 32'd0);
        checkOutput("down_ena0", {31'd0, pwm_ena}, 32'd0);
        checkOutput("down_busy0", {31'd0, busy}, 32'd0);

        // Start and stop together: stop wins, stays IDLE
        applyStimulus(1, 1, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("ss_both_ena", {31'd0, pwm_ena}, 32'd0);
        checkOutput("ss_both_busy", {31'd0, busy}, 32'd0);
        applyStimulus(0, 0, 0, 0);

        // Fault during ramp up at duty 3
        target = 8'd5;
        applyStimulus(1, 0, 0, 0);
        waitDuty("flt_reach3", 8'd3, 60);
        fault = 1'b1;
        @(negedge clk);
        checkOutput("flt_ena", {31'd0, pwm_ena}, 32'd0);
        checkOutput("flt_duty", {24'd0, pwm_duty}, 32'd0);
        checkOutput("flt_faulted", {31'd0, faulted}, 32'd1);
        checkOutput("flt_busy", {31'd0, busy}, 32'd0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checkOutput("flt_clr_blocked", {31'd0, faulted}, 32'd1);
        checkOutput("flt_start_ignored", {31'd0, pwm_ena}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flt_latched", {31'd0, faulted}, 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checkOutput("flt_cleared", {31'd0, faulted}, 32'd0);
        checkOutput("flt_idle_ena", {31'd0, pwm_ena}, 32'd0);
        @(negedge clk);
        checkOutput("flt_idle_hold", {31'd0, pwm_ena}, 32'd0);

        // Fast ramp to 0x40, then asynchronous reset mid-cycle
        prescale = 16'd0;
        ramp_div = 16'd0;
        target   = 8'h40;
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        waitDuty("fast_reach40", 8'h40, 200);
        checkOutput("fast_at_target", {31'd0, at_target}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_ena", {31'd0, pwm_ena}, 32'd0);
        checkOutput("arst_duty", {24'd0, pwm_duty}, 32'd0);
        checkOutput("arst_faulted", {31'd0, faulted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("arst_idle_ena", {31'd0, pwm_ena}, 32'd0);
        checkOutput("arst_idle_duty", {24'd0, pwm_duty}, 32'd0);

        // Saturation at 255
        target = 8'hFF;
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        waitDuty("sat_reach", 8'hFF, 400);
        checkOutput("sat_at_target", {31'd0, at_target}, 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("sat_hold", {24'd0, pwm_duty}, 32'hFF);
        checkOutput("sat_ena", {31'd0, pwm_ena}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
